// File: rtl/axis_frame_conditioner.sv
// AXI4-Stream frame conditioner: forces exactly WIDTH*HEIGHT beats per frame (tuser on beat 0, tlast on N-1).
// Optional frame statistics counters enabled by defining FRAME_STATS_EN.
module axis_frame_conditioner #(
  parameter int unsigned            WIDTH      = 32,
  parameter int unsigned            HEIGHT     = 16,
  parameter int unsigned            DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0]  PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  err_short,
  output logic                  err_long
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_bad
`endif
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, PASS, PAD, DROP} state_t;

  state_t           state, state_next, after_take;
  logic [CNT_W-1:0] pix_cnt;
  logic             load_en, last_slot;
  logic             ready, take, pad, hold_short;
  logic             set_short, set_long;

  assign load_en       = !m_axis_tvalid || m_axis_tready;
  assign last_slot     = (pix_cnt == LAST_IDX);
  assign s_axis_tready = ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // pix_cnt is always 0 in IDLE/DROP, so one take rule covers start beats and mid-frame beats.
  always_comb begin
    ready      = 1'b0;
    take       = 1'b0;
    pad        = 1'b0;
    hold_short = 1'b0;
    case (state)
      IDLE, DROP: begin
        ready = load_en || !s_axis_tuser;
        take  = s_axis_tvalid && ready && s_axis_tuser;
      end
      PASS: begin
        hold_short = s_axis_tvalid && s_axis_tuser && (pix_cnt != '0);
        ready      = load_en && !hold_short;
        take       = s_axis_tvalid && ready;
      end
      PAD:     pad = load_en;
      default: ;
    endcase
    if (rst) begin
      ready      = 1'b0;
      take       = 1'b0;
      pad        = 1'b0;
      hold_short = 1'b0;
    end
    set_long  = take && last_slot && !s_axis_tlast;
    set_short = hold_short || (take && !last_slot && s_axis_tlast);
  end

  always_comb begin
    if (set_long)       after_take = DROP;
    else if (set_short) after_take = PAD;
    else if (last_slot) after_take = IDLE;
    else                after_take = PASS;

    state_next = state;
    case (state)
      IDLE: if (take) state_next = after_take;
      DROP: begin
        if (take)                                      state_next = after_take;
        else if (s_axis_tvalid && ready && s_axis_tlast) state_next = IDLE;
      end
      PASS: begin
        if (hold_short) state_next = PAD;
        else if (take)  state_next = after_take;
      end
      PAD:     if (pad && last_slot) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pix_cnt       <= '0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
    end else begin
      err_short <= set_short;
      err_long  <= set_long;
      if (load_en) begin
        if (take || pad) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= take ? s_axis_tdata : PAD_VALUE;
          m_axis_tuser  <= (pix_cnt == '0);
          m_axis_tlast  <= last_slot;
          pix_cnt       <= last_slot ? '0 : pix_cnt + 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

`ifdef FRAME_STATS_EN
  // The bad flag travels with beat N-1 so a new frame's errors never tag the frame still draining.
  logic frame_bad, m_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_bad  <= 1'b0;
      m_bad      <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      if (load_en && (take || pad) && last_slot) begin
        m_bad     <= frame_bad || set_long;
        frame_bad <= 1'b0;
      end else if (set_short || set_long) begin
        frame_bad <= 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        if (m_bad) frames_bad <= frames_bad + 16'd1;
        else       frames_ok  <= frames_ok + 16'd1;
      end
    end
  end
`else
  // Statistics disabled: no counters.
`endif

endmodule

// File: tb/tb_axis_frame_conditioner.sv
// Bench for axis_frame_conditioner: randomized frames checked against a frame-level reference model.
// Frame counter checks are compiled in when FRAME_STATS_EN is defined.
module tb_axis_frame_conditioner;
  localparam int W = 32, H = 16, DW = 24, N = W * H;
  localparam logic [DW-1:0] PADV = '0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;
  logic          err_short, err_long;
`ifdef FRAME_STATS_EN
  logic [15:0]   frames_ok, frames_bad;
`endif

  axis_frame_conditioner #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .PAD_VALUE(PADV)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .err_short(err_short), .err_long(err_long)
`ifdef FRAME_STATS_EN
    , .frames_ok(frames_ok), .frames_bad(frames_bad)
`endif
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_chk = 0, n_fail = 0;
  beat_t in_q[$], exp_q[$], got_q[$];
  int    exp_short, exp_long, exp_ok = 0, exp_bad = 0;
  int    mon_short = 0, mon_long = 0, stall_err = 0, rdy_err = 0;
  int    first_out_cyc = -1;
  bit    chk_rdy = 1'b0, prev_stall = 1'b0, rdy_tog = 1'b0;
  int    rdy_mode = 0;
  beat_t prev;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || {m_axis_tdata, m_axis_tuser, m_axis_tlast} !== prev))
        stall_err++;
      if (chk_rdy && m_axis_tvalid && !m_axis_tready && s_axis_tvalid && s_axis_tready) rdy_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      end
      if (err_short) mon_short++;
      if (err_long)  mon_long++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev       = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end
  end

  function automatic beat_t mk(input logic [DW-1:0] d, input logic u, input logic l);
    beat_t b;
    b.data = d; b.user = u; b.last = l;
    return b;
  endfunction

  function automatic logic next_rdy();
    rdy_tog = ~rdy_tog;
    case (rdy_mode)
      1:       return rdy_tog;
      2:       return ($urandom_range(99) < 70);
      default: return 1'b1;
    endcase
  endfunction

  // len beats, tuser on the first, tlast on the final one when with_last is set.
  function automatic void add_frame(input int len, input bit with_last);
    for (int i = 0; i < len; i++)
      in_q.push_back(mk(DW'($urandom()), i == 0, with_last && (i == len - 1)));
  endfunction

  function automatic void add_strays(input int cnt);
    for (int i = 0; i < cnt; i++) in_q.push_back(mk(DW'($urandom()), 1'b0, 1'($urandom_range(1))));
  endfunction

  function automatic void add_pad(input int from);
    for (int p = from; p < N; p++) exp_q.push_back(mk(PADV, p == 0, p == N - 1));
  endfunction

  // Frame-level reading of the rules: a frame starts at any tuser beat; everything else between frames is lost.
  function automatic void model();
    int i = 0, k;
    bit bad, done;
    exp_short = 0; exp_long = 0;
    while (i < in_q.size()) begin
      if (!in_q[i].user) begin i++; continue; end
      k = 0; bad = 0; done = 0;
      while (!done) begin
        exp_q.push_back(mk(in_q[i].data, k == 0, k == N - 1));
        if (k == N - 1) begin
          if (!in_q[i].last) begin exp_long++; bad = 1; end
          i++; done = 1;
        end else if (in_q[i].last) begin
          exp_short++; bad = 1; add_pad(k + 1); i++; done = 1;
        end else begin
          i++; k++;
          if (i >= in_q.size()) done = 1;
          else if (in_q[i].user) begin exp_short++; bad = 1; add_pad(k); done = 1; end
        end
      end
      if (bad) exp_bad++; else exp_ok++;
    end
  endfunction

  task automatic start_test();
    in_q.delete(); exp_q.delete(); got_q.delete();
    mon_short = 0; mon_long = 0; stall_err = 0; rdy_err = 0; first_out_cyc = -1;
  endtask

  // Drives in_q with random idle gaps, then waits (bounded) for the expected output count.
  task automatic drive(input int gap_pct, output int acc_cyc);
    int idx = 0, budget = 0;
    acc_cyc = -1;
    while (idx < in_q.size() && budget < 20000) begin
      @(posedge clk); #1;
      m_axis_tready = next_rdy();
      s_axis_tvalid = (int'($urandom_range(99)) >= gap_pct);
      {s_axis_tdata, s_axis_tuser, s_axis_tlast} = in_q[idx];
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
      end
      budget++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 5000) begin
      m_axis_tready = next_rdy();
      @(posedge clk); #1;
      budget++;
    end
    m_axis_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_short, err_long, s_axis_tready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 000000", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_short, err_long, s_axis_tready});
    end
    n_chk++;
    if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_data: got %h, want 0", m_axis_tdata); end
`ifdef FRAME_STATS_EN
    n_chk++;
    if ({frames_ok, frames_bad} !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %h, want 0", {frames_ok, frames_bad}); end
`endif
    rst = 1'b0;
    exp_ok = 0; exp_bad = 0;
  endtask

  task automatic test_clean();
    int acc;
    start_test();
    rdy_mode = 0;
    add_frame(N, 1'b1);
    model();
    drive(0, acc);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clean_count: got %0d, want %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL clean_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (first_out_cyc !== acc + 1) begin n_fail++; $display("FAIL clean_latency: got cycle %0d, want %0d", first_out_cyc, acc + 1); end
    n_chk++;
    if (mon_short != 0 || mon_long != 0) begin n_fail++; $display("FAIL clean_err: got short=%0d long=%0d, want 0 0", mon_short, mon_long); end
`ifdef FRAME_STATS_EN
    n_chk++;
    if (frames_ok !== 16'(exp_ok) || frames_bad !== 16'(exp_bad)) begin
      n_fail++; $display("FAIL clean_stats: got ok=%0d bad=%0d, want %0d %0d", frames_ok, frames_bad, exp_ok, exp_bad);
    end
`endif
  endtask

  task automatic test_strays();
    int acc;
    start_test();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) in_q.push_back(mk(DW'($urandom()), 1'b0, 1'b0));
    add_frame(N, 1'b1);
    model();
    drive(0, acc);
    n_chk++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL strays_count: got %0d, want %0d", got_q.size(), N); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL strays_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (mon_short != 0 || mon_long != 0) begin n_fail++; $display("FAIL strays_err: got short=%0d long=%0d, want 0 0", mon_short, mon_long); end
  endtask

  task automatic test_short();
    int acc;
    start_test();
    rdy_mode = 0;
    add_frame(300, 1'b1);
    model();
    drive(0, acc);
    n_chk++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL short_count: got %0d, want %0d", got_q.size(), N); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL short_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (mon_short != 1 || mon_long != 0) begin n_fail++; $display("FAIL short_err: got short=%0d long=%0d, want 1 0", mon_short, mon_long); end
`ifdef FRAME_STATS_EN
    n_chk++;
    if (frames_ok !== 16'(exp_ok) || frames_bad !== 16'(exp_bad)) begin
      n_fail++; $display("FAIL short_stats: got ok=%0d bad=%0d, want %0d %0d", frames_ok, frames_bad, exp_ok, exp_bad);
    end
`endif
  endtask

  task automatic test_long();
    int acc;
    start_test();
    rdy_mode = 0;
    add_frame(600, 1'b1);
    add_frame(N, 1'b1);
    model();
    drive(0, acc);
    n_chk++;
    if (got_q.size() != 2 * N) begin n_fail++; $display("FAIL long_count: got %0d, want %0d", got_q.size(), 2 * N); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL long_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (mon_short != 0 || mon_long != 1) begin n_fail++; $display("FAIL long_err: got short=%0d long=%0d, want 0 1", mon_short, mon_long); end
  endtask

  task automatic test_stall();
    int acc;
    start_test();
    rdy_mode = 1;
    chk_rdy = 1'b1;
    add_frame(N, 1'b1);
    model();
    drive(0, acc);
    chk_rdy = 1'b0;
    n_chk++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL stall_count: got %0d, want %0d", got_q.size(), N); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL stall_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles, want 0", stall_err); end
    n_chk++;
    if (rdy_err != 0) begin n_fail++; $display("FAIL stall_ready: got %0d cycles ready while stalled, want 0", rdy_err); end
  endtask

  task automatic test_mid_reset();
    int acc;
    start_test();
    rdy_mode = 0;
    add_frame(100, 1'b0);
    drive(0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_short, err_long, s_axis_tready} !== 6'b0 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b data %h, want all 0", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_short, err_long, s_axis_tready}, m_axis_tdata);
    end
    rst = 1'b0;
    exp_ok = 0; exp_bad = 0;
    start_test();
    add_frame(N, 1'b1);
    model();
    drive(0, acc);
    n_chk++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL midrst_count: got %0d, want %0d", got_q.size(), N); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL midrst_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
`ifdef FRAME_STATS_EN
    n_chk++;
    if (frames_ok !== 16'd1 || frames_bad !== 16'd0) begin
      n_fail++; $display("FAIL midrst_stats: got ok=%0d bad=%0d, want 1 0", frames_ok, frames_bad);
    end
`endif
  endtask

  task automatic test_random();
    int acc;
    start_test();
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(5))
        0: add_frame(N, 1'b1);
        1: add_frame(int'($urandom_range(N - 1, 1)), 1'b1);
        2: add_frame(int'($urandom_range(300, 2)), 1'b0);
        3: add_frame(int'($urandom_range(560, N + 1)), 1'b1);
        4: add_strays(int'($urandom_range(4, 1)));
        default: add_frame(1, 1'b1);
      endcase
    end
    add_frame(N, 1'b1);
    model();
    drive(30, acc);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d, want %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_chk++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rand_beat%0d: got %h, want %h", j, got_q[j], exp_q[j]); end
    end
    n_chk++;
    if (mon_short != exp_short || mon_long != exp_long) begin
      n_fail++; $display("FAIL rand_err: got short=%0d long=%0d, want %0d %0d", mon_short, mon_long, exp_short, exp_long);
    end
    n_chk++;
    if (stall_err != 0) begin n_fail++; $display("FAIL rand_hold: got %0d unstable cycles, want 0", stall_err); end
`ifdef FRAME_STATS_EN
    n_chk++;
    if (frames_ok !== 16'(exp_ok) || frames_bad !== 16'(exp_bad)) begin
      n_fail++; $display("FAIL rand_stats: got ok=%0d bad=%0d, want %0d %0d", frames_ok, frames_bad, exp_ok, exp_bad);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean();
    test_strays();
    test_short();
    test_long();
    test_stall();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
